// File: rtl/framebuffer_dual.sv
// framebuffer_dual: double-buffered 16-bit pixel store.
// Pixel writes land in the back bank. The front bank is streamed out in raster
// order over a valid/ready scanout port. Bank swaps wait for a frame boundary.
// Optional feature macro: FB_FRAME_COUNT_EN adds a 16-bit frame_count output
// that counts executed swaps.
module framebuffer_dual #(
   parameter int FB_WIDTH  = 400,
   parameter int FB_HEIGHT = 240
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [$clog2(FB_WIDTH):0]     fb_x,
   input  logic [$clog2(FB_HEIGHT):0]    fb_y,
   input  logic [15:0]                   fb_color,
   input  logic                          fb_write,
   input  logic                          ctrl_swap,
   output logic                          ctrl_busy,
   input  logic                          scan_start,
   input  logic                          scan_ready,
   output logic                          scan_valid,
   output logic [15:0]                   scan_color,
   output logic [$clog2(FB_WIDTH):0]     scan_x,
   output logic [$clog2(FB_HEIGHT):0]    scan_y,
   output logic                          scan_last
`ifdef FB_FRAME_COUNT_EN
   ,
   output logic [15:0]                   frame_count
`endif
);

   localparam int XW    = $clog2(FB_WIDTH) + 1;
   localparam int YW    = $clog2(FB_HEIGHT) + 1;
   localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [XW-1:0] X_LIM = XW'(FB_WIDTH);
   localparam logic [XW-1:0] X_END = XW'(FB_WIDTH - 1);
   localparam logic [YW-1:0] Y_LIM = YW'(FB_HEIGHT);
   localparam logic [YW-1:0] Y_END = YW'(FB_HEIGHT - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_READ = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            front_q;
   logic            pending_q;
   logic            swap_prev_q;
   logic            start_prev_q;
   logic [XW-1:0]   cnt_x_q;
   logic [YW-1:0]   cnt_y_q;
   logic [XW-1:0]   scan_x_q;
   logic [YW-1:0]   scan_y_q;
   logic            valid_q;
   logic            last_q;
   logic            sel_q;

   logic            swap_ev;
   logic            start_ev;
   logic            last_accept;
   logic            swap_now;
   logic            load;
   logic            cnt_at_end;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [AW-1:0]   rd_addr;

   assign swap_ev     = ctrl_swap & ~swap_prev_q;
   assign start_ev    = scan_start & ~start_prev_q;
   // scan_last is only ever presented while reading, so this marks end of frame.
   assign last_accept = valid_q & scan_ready & last_q;
   // A pending swap only executes between frames, never mid-frame.
   assign swap_now    = pending_q & ((state_q == S_IDLE) | last_accept);
   assign cnt_at_end  = (cnt_x_q == X_END) && (cnt_y_q == Y_END);

   assign wr_en   = fb_write && (fb_x < X_LIM) && (fb_y < Y_LIM);
   assign wr_addr = AW'(fb_x) + AW'(fb_y) * AW'(FB_WIDTH);
   assign rd_addr = AW'(cnt_x_q) + AW'(cnt_y_q) * AW'(FB_WIDTH);

   // Input history for rising-edge detection of the two request lines.
   always_ff @(posedge clk) begin
      if (reset) begin
         swap_prev_q  <= 1'b0;
         start_prev_q <= 1'b0;
      end else begin
         swap_prev_q  <= ctrl_swap;
         start_prev_q <= scan_start;
      end
   end

   // Swap bookkeeping; requests arriving while one is pending merge into it.
   always_ff @(posedge clk) begin
      if (reset) begin
         front_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         if (swap_now) begin
            front_q   <= ~front_q;
            pending_q <= 1'b0;
         end else if (swap_ev) begin
            pending_q <= 1'b1;
         end
      end
   end

   // Scanout state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Scanout next state; load refills the output slot when empty or accepted.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_ev) begin
               state_d = S_READ;
            end
         end
         S_READ: begin
            if (last_accept) begin
               state_d = S_IDLE;
            end else if (!valid_q || scan_ready) begin
               load = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Raster read counter and the presented-pixel tag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_x_q  <= '0;
         cnt_y_q  <= '0;
         scan_x_q <= '0;
         scan_y_q <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         sel_q    <= 1'b0;
      end else if ((state_q == S_IDLE) && start_ev) begin
         cnt_x_q <= '0;
         cnt_y_q <= '0;
      end else if (load) begin
         scan_x_q <= cnt_x_q;
         scan_y_q <= cnt_y_q;
         last_q   <= cnt_at_end;
         sel_q    <= front_q;
         valid_q  <= 1'b1;
         if (cnt_x_q == X_END) begin
            cnt_x_q <= '0;
            cnt_y_q <= (cnt_y_q == Y_END) ? '0 : cnt_y_q + YW'(1);
         end else begin
            cnt_x_q <= cnt_x_q + XW'(1);
         end
      end else if (last_accept) begin
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end
   end

   // Two pixel banks; each is written only as the back bank and read only as
   // the front bank, so one write port and one read port are live at a time.
   for (genvar gi = 0; gi < 2; gi++) begin : bank_g
      logic [15:0] mem [DEPTH];
      logic [15:0] rd_q;

      // Back-bank write and front-bank registered read with enable.
      always_ff @(posedge clk) begin
         if (wr_en && (front_q != 1'(gi))) begin
            mem[wr_addr] <= fb_color;
         end
         if (load && (front_q == 1'(gi))) begin
            rd_q <= mem[rd_addr];
         end
      end
   end

   // RAM read registers are not reset, so the colour is masked while idle.
   assign scan_color = valid_q ? (sel_q ? bank_g[1].rd_q : bank_g[0].rd_q) : 16'h0000;
   assign scan_valid = valid_q;
   assign scan_x     = scan_x_q;
   assign scan_y     = scan_y_q;
   assign scan_last  = last_q;
   assign ctrl_busy  = pending_q;

`ifdef FB_FRAME_COUNT_EN
   logic [15:0] frame_cnt_q;

   // Counts executed swaps, wrapping naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= 16'h0000;
      end else if (swap_now) begin
         frame_cnt_q <= frame_cnt_q + 16'h0001;
      end
   end

   assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_framebuffer_dual.sv
// Testbench for framebuffer_dual at 4x3 pixels: table-driven writes, directed
// frame sequences and randomized traffic against a bank-level reference model.
module tb_framebuffer_dual;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  fb_x;
   logic [2:0]  fb_y;
   logic [15:0] fb_color;
   logic        fb_write;
   logic        ctrl_swap;
   logic        ctrl_busy;
   logic        scan_start;
   logic        scan_ready;
   logic        scan_valid;
   logic [15:0] scan_color;
   logic [2:0]  scan_x;
   logic [2:0]  scan_y;
   logic        scan_last;
`ifdef FB_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   framebuffer_dual #(
      .FB_WIDTH (W),
      .FB_HEIGHT(H)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fb_x       (fb_x),
      .fb_y       (fb_y),
      .fb_color   (fb_color),
      .fb_write   (fb_write),
      .ctrl_swap  (ctrl_swap),
      .ctrl_busy  (ctrl_busy),
      .scan_start (scan_start),
      .scan_ready (scan_ready),
      .scan_valid (scan_valid),
      .scan_color (scan_color),
      .scan_x     (scan_x),
      .scan_y     (scan_y),
      .scan_last  (scan_last)
`ifdef FB_FRAME_COUNT_EN
      ,
      .frame_count(frame_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          x;
      int          y;
      logic [15:0] color;
      int          exp_addr;   // -1: write must be dropped
   } wr_vec_t;

   wr_vec_t     wr_tab[10];

   int          vecs = 0;
   int          miss = 0;

   // Reference model: bank contents, which bank is displayed, pending swap.
   logic [15:0] model_bank[2][N];
   int          model_front;
   int          model_pending;
   int          model_fc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fc();
`ifdef FB_FRAME_COUNT_EN
      chk("frame_count", frame_count, 32'(model_fc));
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      model_front   = 0;
      model_pending = 0;
      model_fc      = 0;
   endtask

   task automatic wr_px(input int x, input int y, input logic [15:0] c, input int exp_addr);
      fb_x     = 3'(x);
      fb_y     = 3'(y);
      fb_color = c;
      fb_write = 1'b1;
      step();
      fb_write = 1'b0;
      if (exp_addr >= 0) model_bank[1 - model_front][exp_addr] = c;
      $display("write (%0d,%0d) color 0x%h -> addr %0d", x, y, c, exp_addr);
   endtask

   // Swap request while idle: pending for one cycle, then executed.
   task automatic do_swap();
      ctrl_swap = 1'b1;
      step();
      ctrl_swap = 1'b0;
      chk("busy_after_req", ctrl_busy, 1);
      step();
      model_front = 1 - model_front;
      model_fc    = (model_fc + 1) & 16'hFFFF;
      chk("busy_after_swap", ctrl_busy, 0);
      check_fc();
      $display("swap done, front now %0d", model_front);
   endtask

   // One full frame. stall_beat: drop ready 3 cycles on that beat (<=0 none);
   // rand_ready: random ready; swap_beat: pulse ctrl_swap on that beat (<=0 none).
   task automatic scan_frame(input int stall_beat, input bit rand_ready, input int swap_beat);
      logic [15:0] exp_frame[N];
      logic [15:0] h_color;
      logic [2:0]  h_x;
      logic [2:0]  h_y;
      logic        h_last;
      bit          held = 1'b0;
      bit          accept;
      bit          swap_set;
      bit          swap_done = 1'b0;
      int          idx = 0;
      int          cycles = 0;
      int          stall_left = 3;
      int          guard = 0;
      h_color = '0;
      h_x     = '0;
      h_y     = '0;
      h_last  = 1'b0;
      for (int i = 0; i < N; i++) exp_frame[i] = model_bank[model_front][i];
      scan_ready = 1'b1;
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      chk("first_beat_lat1_valid", scan_valid, 0);
      step();
      chk("first_beat_lat2_valid", scan_valid, 1);
      while (idx < N && guard < 200) begin
         guard++;
         cycles++;
         if (held) begin
            chk($sformatf("hold%0d_color", idx + 1), scan_color, h_color);
            chk($sformatf("hold%0d_x", idx + 1), scan_x, h_x);
            chk($sformatf("hold%0d_y", idx + 1), scan_y, h_y);
            chk($sformatf("hold%0d_last", idx + 1), scan_last, h_last);
         end
         if (scan_valid && (idx + 1 == stall_beat) && stall_left > 0) begin
            scan_ready = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            scan_ready = 1'($urandom_range(0, 1));
         end else begin
            scan_ready = 1'b1;
         end
         swap_set = 1'b0;
         if (scan_valid && (idx + 1 == swap_beat) && !swap_done) begin
            ctrl_swap = 1'b1;
            swap_set  = 1'b1;
            swap_done = 1'b1;
         end
         accept = scan_valid && scan_ready;
         if (accept) begin
            chk($sformatf("beat%0d_color", idx + 1), scan_color, exp_frame[idx]);
            chk($sformatf("beat%0d_x", idx + 1), scan_x, idx % W);
            chk($sformatf("beat%0d_y", idx + 1), scan_y, idx / W);
            chk($sformatf("beat%0d_last", idx + 1), scan_last, (idx == N - 1) ? 1 : 0);
            idx++;
         end
         held    = scan_valid && !scan_ready;
         h_color = scan_color;
         h_x     = scan_x;
         h_y     = scan_y;
         h_last  = scan_last;
         step();
         ctrl_swap = 1'b0;
         // A swap already pending executes with the end-of-frame acceptance.
         if (accept && idx == N && model_pending != 0) begin
            model_front   = 1 - model_front;
            model_pending = 0;
            model_fc      = (model_fc + 1) & 16'hFFFF;
         end
         if (swap_set) model_pending = 1;
         chk("busy_in_frame", ctrl_busy, 32'(model_pending));
      end
      if (idx < N) begin
         vecs++;
         miss++;
         $display("FAIL scan_timeout: got %0d beats, want %0d", idx, N);
      end
      chk("valid_after_last", scan_valid, 0);
      if (!rand_ready) chk("frame_cycles", cycles, N + ((stall_beat > 0) ? 3 : 0));
      // A request that landed on the last beat executes in the idle cycle after.
      if (model_pending != 0) begin
         step();
         model_front   = 1 - model_front;
         model_pending = 0;
         model_fc      = (model_fc + 1) & 16'hFFFF;
         chk("busy_after_idle_swap", ctrl_busy, 0);
      end
      check_fc();
      $display("frame: %0d beats in %0d cycles, front now %0d", idx, cycles, model_front);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_tab[0] = '{0, 0, 16'hA000, 0};
      wr_tab[1] = '{3, 0, 16'hA003, 3};
      wr_tab[2] = '{2, 1, 16'hA006, 6};
      wr_tab[3] = '{0, 2, 16'hA008, 8};
      wr_tab[4] = '{3, 2, 16'hA00B, 11};
      wr_tab[5] = '{4, 0, 16'hFFFF, -1};
      wr_tab[6] = '{0, 3, 16'hFFFF, -1};
      wr_tab[7] = '{7, 7, 16'hFFFF, -1};
      wr_tab[8] = '{5, 1, 16'hFFFF, -1};
      wr_tab[9] = '{1, 4, 16'hFFFF, -1};

      reset      = 1'b1;
      fb_x       = '0;
      fb_y       = '0;
      fb_color   = '0;
      fb_write   = 1'b0;
      ctrl_swap  = 1'b0;
      scan_start = 1'b0;
      scan_ready = 1'b0;
      model_front   = 0;
      model_pending = 0;
      model_fc      = 0;

      do_reset();
      chk("rst_valid", scan_valid, 0);
      chk("rst_color", scan_color, 0);
      chk("rst_x", scan_x, 0);
      chk("rst_y", scan_y, 0);
      chk("rst_last", scan_last, 0);
      chk("rst_busy", ctrl_busy, 0);
      check_fc();

      // Fill bank 1, swap it to the front, fill bank 0 with a different pattern.
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) wr_px(x, y, 16'h1000 + 16'(x + 4 * y), x + 4 * y);
      do_swap();
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) wr_px(x, y, 16'h2000 + 16'(x + 4 * y), x + 4 * y);

      // Full-speed frame, then the same frame with backpressure on beat 5.
      scan_frame(0, 1'b0, 0);
      scan_frame(5, 1'b0, 0);

      // Table writes into the back bank, out-of-bounds ones must vanish.
      for (int i = 0; i < 10; i++) wr_px(wr_tab[i].x, wr_tab[i].y, wr_tab[i].color, wr_tab[i].exp_addr);
      do_swap();

      // Swap requested at beat 6 takes effect only after the frame.
      scan_frame(0, 1'b0, 6);
      scan_frame(0, 1'b0, 0);

      // Write on the cycle the swap executes goes to the pre-swap back bank.
      ctrl_swap = 1'b1;
      step();
      ctrl_swap = 1'b0;
      chk("wswap_busy_pending", ctrl_busy, 1);
      fb_x     = 3'd1;
      fb_y     = 3'd1;
      fb_color = 16'hBEEF;
      fb_write = 1'b1;
      step();
      fb_write = 1'b0;
      model_bank[1 - model_front][5] = 16'hBEEF;
      model_front = 1 - model_front;
      model_fc    = (model_fc + 1) & 16'hFFFF;
      chk("wswap_busy_done", ctrl_busy, 0);
      scan_frame(0, 1'b0, 0);

      // Reset in the middle of a frame with a swap pending.
      if (model_front == 0) do_swap();
      scan_ready = 1'b1;
      scan_start = 1'b1;
      step();
      scan_start = 1'b0;
      step();
      for (int k = 0; k < 6; k++) begin
         ctrl_swap = (k == 2);
         step();
      end
      ctrl_swap = 1'b0;
      chk("midrst_beat7_color", scan_color, model_bank[model_front][6]);
      chk("midrst_busy_before", ctrl_busy, 1);
      reset = 1'b1;
      step();
      model_front   = 0;
      model_pending = 0;
      model_fc      = 0;
      chk("midrst_valid", scan_valid, 0);
      chk("midrst_busy", ctrl_busy, 0);
      chk("midrst_color", scan_color, 0);
      chk("midrst_x", scan_x, 0);
      chk("midrst_y", scan_y, 0);
      check_fc();
      reset = 1'b0;
      step();
      scan_frame(0, 1'b0, 0);
      do_swap();
      do_swap();

      // Randomized writes, swaps and ready patterns.
      repeat (5) begin
         repeat (16) begin
            int rx;
            int ry;
            rx = $urandom_range(0, 7);
            ry = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
            wr_px(rx, ry, 16'($urandom), (rx < W && ry < H) ? rx + W * ry : -1);
         end
         if ($urandom_range(0, 1) == 1) do_swap();
         scan_frame(0, 1'b1, $urandom_range(0, N));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/framebuffer_dual.md
Name: framebuffer_dual

Overview:
Double-buffered pixel store that sits on the receiving end of the GPU's framebuffer write port (fb_x/fb_y/fb_color/fb_write).
- Pixel writes always land in the back bank.
- A streaming scanout port feeds the display controller from the front bank, using a valid/ready handshake.
- Bank swaps are requested by the controller and take effect only at frame boundaries, so a displayed frame never tears.

Parameters:
FB_WIDTH, 400, pixels per line
FB_HEIGHT, 240, lines per frame
(derived) AW = $clog2(FB_WIDTH*FB_HEIGHT), linear pixel address width per bank

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fb_x  in  $clog2(FB_WIDTH)+1  write x coordinate
fb_y  in  $clog2(FB_HEIGHT)+1  write y coordinate
fb_color  in  16  write color
fb_write  in  1  write strobe, one pixel per cycle
ctrl_swap  in  1  swap request, rising-edge triggered
ctrl_busy  out  1  high while a swap is pending
scan_start  in  1  frame start request, rising-edge triggered
scan_ready  in  1  consumer accepts the current pixel
scan_valid  out  1  scan_color/scan_x/scan_y/scan_last are valid
scan_color  out  16  front-bank pixel
scan_x  out  $clog2(FB_WIDTH)+1  x of the presented pixel
scan_y  out  $clog2(FB_HEIGHT)+1  y of the presented pixel
scan_last  out  1  presented pixel is (FB_WIDTH-1, FB_HEIGHT-1)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: front=0, swap_pending=0, scan FSM=IDLE, scan_valid=0, scan_color=0, scan_x=0, scan_y=0, scan_last=0, ctrl_busy=0. RAM contents are not reset.
- Edge detect: ctrl_swap and scan_start each use a registered previous value (cleared on reset). An event fires when prev==0 && cur==1.
- Writes:
  - When fb_write=1 and fb_x<FB_WIDTH and fb_y<FB_HEIGHT, fb_color is stored at address fb_x + fb_y*FB_WIDTH in bank !front on that clock edge.
  - Out-of-bounds writes are silently dropped. Comparisons are unsigned.
  - Bank selection uses the front value before any same-cycle swap.
- RAM: two banks of FB_WIDTH*FB_HEIGHT x16 words with synchronous reads (1-cycle latency), inferable as block RAM. There is one write port (back bank) and one read port (front bank).
- Scanout FSM, states IDLE and READ:
  - IDLE -> READ on a scan_start event at cycle N. The read counter resets to (0,0); the address is issued at N+1; the first pixel has scan_valid=1 at N+2.
  - In READ, the output register is loaded whenever it is empty or its pixel is accepted (scan_valid && scan_ready). The read address advances under the same condition.
  - With scan_ready held high, throughput is 1 pixel per cycle, with no bubbles after the first pixel.
  - While scan_valid=1 and scan_ready=0, all scan_* outputs hold stable.
  - Pixel order is raster: x increments from 0 to FB_WIDTH-1, then wraps to 0 with y+1.
  - READ -> IDLE when the pixel with scan_last=1 is accepted. scan_valid=0 on the following cycle unless a new frame has been requested.
  - A scan_start event during READ is ignored.
- Swap:
  - A ctrl_swap event sets swap_pending. ctrl_busy = swap_pending.
  - The swap executes (front <= !front, swap_pending <= 0) on the first cycle in which either the FSM is IDLE, or the scan_last pixel is accepted.
  - If the scan_start event and the swap both fall in the same IDLE cycle, the swap executes first, so the new frame reads the new front bank.
  - A ctrl_swap event while swap_pending=1 merges into the pending swap: only one swap occurs.
  - The front bank never changes mid-frame.
- Reset mid-frame: the FSM returns to IDLE, scan_valid=0 on the next cycle, and the pending swap is discarded.

Optional Feature:
FB_FRAME_COUNT_EN:
- Defined: adds output port frame_count [15:0]. It is reset to 0 and increments by 1 on every executed swap, wrapping 0xFFFF->0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use FB_WIDTH=4, FB_HEIGHT=3.
- Fill back bank with color 0x1000+x+4y, pulse ctrl_swap, then pulse scan_start with scan_ready=1 -> 12 beats of color 0x1000..0x100B on consecutive cycles. First beat arrives 2 cycles after the scan_start edge; scan_last=1 only on beat 12 with (3,2).
- Write (4,0), (0,3) and (7,7) with color 0xFFFF -> no RAM location changes; a scanout after a swap shows the prior contents.
- Backpressure: drop scan_ready for 3 cycles at beat 5 -> scan_color/scan_x/scan_y hold at 0x1004/(0,1) for those 3 cycles; no beat is lost or duplicated.
- ctrl_swap at beat 6 of a frame -> ctrl_busy=1 until the scan_last acceptance. The remaining beats come from the old bank, and the next frame reads the new bank.
- Write to (1,1) in the same cycle a swap executes -> data lands in the pre-swap back bank, which is the new front bank, and appears in the next frame at beat 6.
- Assert reset at beat 7 -> scan_valid=0 the next cycle, ctrl_busy=0, front=0. With FB_FRAME_COUNT_EN defined, frame_count=0 after reset and counts 1, 2 after two executed swaps.
